delay_prog_multi: RTL and testbench

Clocked, multi-bit delay line whose depth is selectable at run time from 0 to a parametrised maximum, with a fill tracker that tells the consumer when the output reflects real history. It generalises the fixed-T per-bit delay chain into one shared circular buffer with clock enable, synchronous flush and an output-valid flag. It sits wherever a bus must be retimed by a programmable number of cycles, for example when aligning data paths of unequal latency.

---
 rtl/delay_prog_multi.sv | 71 +++++++
 tb/tb_delay_prog_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/delay_prog_multi.sv
// Run-time programmable delay line: one shared circular buffer, a fill counter
// gating the output-valid flag, and a zero-delay combinational bypass.
module delay_prog_multi #(
  parameter int   N    = 1,
  parameter int   D    = 16,
  parameter logic Rval = 1'b0,
  localparam int  DW   = $clog2(D+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i,
  input  logic          en,
  input  logic          flush,
  input  logic [DW-1:0] dly,
  output logic [N-1:0]  o,
  output logic          ov
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [N-1:0]  mem [D];
  logic [AW-1:0] wp;
  logic [DW-1:0] cnt;
  logic [DW-1:0] k;
  logic [AW:0]   raw;
  logic [AW-1:0] ridx;
  logic          hit;

  always_comb begin
    k = (32'(dly) > 32'(D)) ? DW'(D) : dly;
  end

  // (wp - k) mod D; with k = D this lands on wp, the oldest entry, read before the edge
  always_comb begin
    raw  = {1'b0, wp} + (AW+1)'(D) - (AW+1)'(k);
    ridx = (raw >= (AW+1)'(D)) ? AW'(raw - (AW+1)'(D)) : raw[AW-1:0];
    hit  = (cnt >= k);
  end

  always_comb begin
    o  = {N{Rval}};
    ov = 1'b0;
    if (rst) begin
      if (k == '0) begin
        o  = i;
        ov = 1'b1;
      end else if (hit) begin
        o  = mem[ridx];
        ov = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (en) begin
      if (flush) begin
        cnt <= '0;
      end else begin
        wp <= (wp == AW'(D-1)) ? '0 : wp + 1'b1;
        if (cnt != DW'(D)) cnt <= cnt + 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are masked by cnt
  always_ff @(posedge clk) begin
    if (en && !flush) mem[wp] <= i;
  end
endmodule

// File: tb/tb_delay_prog_multi.sv
// Bench for delay_prog_multi: directed scenarios on an 8x16 instance and
// randomized traffic on a 5x7 instance, both against a queue-based history model.
module tb_delay_prog_multi;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, en8, fl8, ov8;
  logic [7:0] i8, o8;
  logic [4:0] dly8;

  logic       rst5, en5, fl5, ov5;
  logic [4:0] i5, o5;
  logic [2:0] dly5;

  delay_prog_multi #(.N(8), .D(16), .Rval(1'b0)) u8 (
    .clk(clk), .rst(rst8), .i(i8), .en(en8), .flush(fl8), .dly(dly8), .o(o8), .ov(ov8));
  delay_prog_multi #(.N(5), .D(7), .Rval(1'b0)) u5 (
    .clk(clk), .rst(rst5), .i(i5), .en(en5), .flush(fl5), .dly(dly5), .o(o5), .ov(ov5));

  int checks = 0, failures = 0;
  logic [7:0] h8[$];
  logic [7:0] h5[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output from the enabled-edge history (newest at the back)
  function automatic void ref_out(input logic [7:0] q[$], input int d, input int dmax,
                                  input logic r, input logic [7:0] vi,
                                  output logic [7:0] eo, output logic eov);
    int k;
    k = (d > dmax) ? dmax : d;
    eo = 8'h00; eov = 1'b0;
    if (r) begin
      if (k == 0) begin eo = vi; eov = 1'b1; end
      else if (q.size() >= k) begin eo = q[q.size()-k]; eov = 1'b1; end
    end
  endfunction

  task automatic check8(input string tag);
    logic [7:0] eo; logic eov;
    ref_out(h8, int'(dly8), 16, rst8, i8, eo, eov);
    chk({tag, ".o"}, 32'(o8), 32'(eo));
    chk({tag, ".ov"}, 32'(ov8), 32'(eov));
  endtask

  task automatic check5(input string tag);
    logic [7:0] eo; logic eov;
    ref_out(h5, int'(dly5), 7, rst5, {3'b0, i5}, eo, eov);
    chk({tag, ".o"}, 32'(o5), 32'(eo));
    chk({tag, ".ov"}, 32'(ov5), 32'(eov));
  endtask

  // One cycle on the 8-bit instance: drive at negedge, check pre-edge and post-edge
  task automatic cyc8(input logic [7:0] vi, input logic ve, input logic vf, input logic [4:0] vd);
    i8 = vi; en8 = ve; fl8 = vf; dly8 = vd;
    #1 check8("d8pre");
    @(posedge clk);
    if (rst8 && ve) begin
      if (vf) h8.delete();
      else begin
        h8.push_back(vi);
        if (h8.size() > 16) void'(h8.pop_front());
      end
    end
    #1 check8("d8post");
    @(negedge clk);
  endtask

  task automatic cyc5(input logic [4:0] vi, input logic ve, input logic vf, input logic [2:0] vd);
    i5 = vi; en5 = ve; fl5 = vf; dly5 = vd;
    #1 check5("r5pre");
    @(posedge clk);
    if (rst5 && ve) begin
      if (vf) h5.delete();
      else begin
        h5.push_back({3'b0, vi});
        if (h5.size() > 7) void'(h5.pop_front());
      end
    end
    #1 check5("r5post");
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    rst8 = 1'b0; en8 = 1'b0; fl8 = 1'b0; i8 = 8'h00; dly8 = 5'd3;
    rst5 = 1'b0; en5 = 1'b0; fl5 = 1'b0; i5 = 5'd0; dly5 = 3'd0;
    @(negedge clk);
    #1 chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_o", 32'(o8), 32'h00);
    dly8 = 5'd0; i8 = 8'hA5;
    #1 chk("rst_byp_ov", 32'(ov8), 32'd0);
    chk("rst_byp_o", 32'(o8), 32'h00);
    @(negedge clk);
    rst8 = 1'b1;

    // bypass before any edge
    cyc8(8'h5A, 1'b0, 1'b0, 5'd0);
    chk("byp_o", 32'(o8), 32'h5A);
    chk("byp_ov", 32'(ov8), 32'd1);

    // reset/fill with dly=3
    for (int n = 0; n < 20; n++) begin
      cyc8(8'h10 + 8'(n), 1'b1, 1'b0, 5'd3);
      if (n < 2) chk("fill_ov_lo", 32'(ov8), 32'd0);
      if (n == 2) chk("fill_e3", 32'(o8), 32'h10);
      if (n == 3) chk("fill_e4", 32'(o8), 32'h11);
    end

    // clamp: dly=31 behaves as 16
    for (int n = 0; n < 20; n++) cyc8(8'h40 + 8'(n), 1'b1, 1'b0, 5'd31);
    chk("clamp_o", 32'(o8), 32'h44);

    // run-time change 5 -> 2 after a fresh 16-edge ramp
    cyc8(8'hEE, 1'b1, 1'b1, 5'd5);
    for (int n = 0; n < 16; n++) cyc8(8'h80 + 8'(n), 1'b1, 1'b0, 5'd5);
    chk("dly5_o", 32'(o8), 32'h8B);
    cyc8(8'hC0, 1'b0, 1'b0, 5'd2);
    chk("dly2_jump", 32'(o8), 32'h8E);
    chk("dly2_ov", 32'(ov8), 32'd1);

    // flush together with a switch to 16, then refill
    cyc8(8'hEE, 1'b1, 1'b1, 5'd16);
    chk("flush16_ov", 32'(ov8), 32'd0);
    for (int n = 0; n < 16; n++) begin
      cyc8(8'h20 + 8'(n), 1'b1, 1'b0, 5'd16);
      if (n == 14) chk("g16_ov_e15", 32'(ov8), 32'd0);
    end
    chk("g16_ov_e16", 32'(ov8), 32'd1);
    chk("g16_o", 32'(o8), 32'h20);

    // enable gaps: delay counts enabled edges only
    cyc8(8'h60, 1'b1, 1'b0, 5'd2);
    for (int n = 0; n < 4; n++) cyc8(8'(($urandom)), 1'b0, 1'($urandom), 5'd2);
    chk("gap_o", 32'(o8), 32'h2F);
    cyc8(8'h61, 1'b1, 1'b0, 5'd2);
    chk("gap_resume", 32'(o8), 32'h60);

    // asynchronous reset mid-stream with dly=4
    for (int n = 0; n < 6; n++) cyc8(8'h70 + 8'(n), 1'b1, 1'b0, 5'd4);
    chk("pre_arst_ov", 32'(ov8), 32'd1);
    #2 rst8 = 1'b0;
    h8.delete();
    #1 chk("arst_o", 32'(o8), 32'h00);
    chk("arst_ov", 32'(ov8), 32'd0);
    @(negedge clk);
    cyc8(8'h99, 1'b1, 1'b0, 5'd4);
    rst8 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cyc8(8'h10 + 8'(n), 1'b1, 1'b0, 5'd3);
      if (n == 1) chk("refill_lo", 32'(ov8), 32'd0);
      if (n == 2) chk("refill_e3", 32'(o8), 32'h10);
    end

    // randomized traffic on the 5x7 instance
    rst5 = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        rst5 = 1'b0;
        h5.delete();
      end else begin
        rst5 = 1'b1;
      end
      cyc5(v[4:0], ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
